// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, data width and
// the clock-divider helper used to derive the bit period from clock and baud.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } uart_state_e;

  // Integer truncation; callers rely on the result being at least 4.
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage : uart_pkg

// File: rtl/uart_rx_deserializer_if.sv
// Byte-side interface of the UART receiver: valid/ready byte stream plus
// error and status flags. master = receiver, slave = consuming core logic.
interface uart_rx_deserializer_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_ready;
  logic                      frame_err;
  logic                      overrun;
  logic                      err_clr;
  logic                      busy;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    output busy,
    input  rx_ready,
    input  err_clr
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  busy,
    output rx_ready,
    output err_clr
  );

endinterface : uart_rx_deserializer_if

// File: rtl/uart_rx_deserializer_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// parameterised reset value so an idle-high line resets to its idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs at the same edge and the chain really is two stages deep.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff

// File: rtl/uart_rx_deserializer.sv
// UART 8N1 receiver: synchronizes the serial line, samples each bit at its
// centre and presents completed bytes on a valid/ready interface.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 27_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   uart_rx,
  uart_rx_deserializer_if.master bus
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW    = $clog2(CPB);
  localparam int IDX_W = $clog2(UART_DATA_BITS);

  localparam logic [CW-1:0]    BIT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0]    HALF_LAST = CW'(CPB / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

  logic rxs;

  uart_state_e               state, state_next;
  logic [CW-1:0]             counter, counter_next;
  logic [IDX_W-1:0]          bit_idx, bit_idx_next;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      sample;
  logic                      deliver;
  logic                      stop_bad;

  logic [UART_DATA_BITS-1:0] rx_data_q;
  logic                      rx_valid_q;
  logic                      frame_err_q;
  logic                      overrun_q;
  logic                      accept;
  logic                      take;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_rx),
    .q   (rxs)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      counter <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
      bit_idx <= bit_idx_next;
      if (sample) shift[bit_idx] <= rxs;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    bit_idx_next = bit_idx;
    sample       = 1'b0;
    deliver      = 1'b0;
    stop_bad     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        counter_next = '0;
        if (!rxs) state_next = ST_START;
      end

      // Re-check the line at mid start bit so short glitches are rejected.
      ST_START: begin
        if (counter == HALF_LAST) begin
          counter_next = '0;
          bit_idx_next = '0;
          state_next   = rxs ? ST_IDLE : ST_DATA;
        end else begin
          counter_next = counter + CW'(1);
        end
      end

      ST_DATA: begin
        if (counter == BIT_LAST) begin
          counter_next = '0;
          sample       = 1'b1;
          bit_idx_next = bit_idx + IDX_W'(1);
          if (bit_idx == IDX_LAST) state_next = ST_STOP;
        end else begin
          counter_next = counter + CW'(1);
        end
      end

      ST_STOP: begin
        if (counter == BIT_LAST) begin
          counter_next = '0;
          if (rxs) begin
            deliver    = 1'b1;
            state_next = ST_IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = ST_WAIT_IDLE;
          end
        end else begin
          counter_next = counter + CW'(1);
        end
      end

      // A held break must return high before another start can be detected.
      ST_WAIT_IDLE: begin
        if (rxs) state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign accept = rx_valid_q & bus.rx_ready;
  assign take   = deliver & (~rx_valid_q | bus.rx_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= stop_bad;

      if (take) begin
        rx_data_q  <= shift;
        rx_valid_q <= 1'b1;
      end else if (accept) begin
        rx_valid_q <= 1'b0;
      end

      // A dropped byte outranks a simultaneous clear request.
      if (deliver && !take) overrun_q <= 1'b1;
      else if (bus.err_clr) overrun_q <= 1'b0;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state != ST_IDLE);

endmodule : uart_rx_deserializer
